// File: rtl/ram_fifo_ctrl_if.sv
// Producer/consumer handshake plus external 4x2 RAM port for ram_fifo_ctrl.
// slave is the controller side; master is the environment (producer, consumer, RAM).
interface ram_fifo_ctrl_if;
  localparam int unsigned DATA_W  = 2;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned COUNT_W = 3;

  logic [DATA_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  mem_address;
  logic [DATA_W-1:0]  mem_Din;
  logic               mem_WR;
  logic [DATA_W-1:0]  mem_Dout;
  logic [COUNT_W-1:0] count;

  modport slave (
    input  in_data, in_valid, out_ready, mem_Dout,
    output in_ready, out_data, out_valid, mem_address, mem_Din, mem_WR, count
  );

  modport master (
    output in_data, in_valid, out_ready, mem_Dout,
    input  in_ready, out_data, out_valid, mem_address, mem_Din, mem_WR, count
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// 5-entry FIFO: 4 entries in an external single-port synchronous RAM plus one
// output holding register. Reads take priority over writes on the shared port.
module ram_fifo_ctrl (
  input  logic             clk,
  input  logic             rst,
  ram_fifo_ctrl_if.slave   bus
);
  localparam int unsigned DATA_W  = 2;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned COUNT_W = 3;
  localparam int unsigned DEPTH   = 4;

  logic [ADDR_W-1:0]  wr_ptr, wr_ptr_n;
  logic [ADDR_W-1:0]  rd_ptr, rd_ptr_n;
  logic [COUNT_W-1:0] mem_cnt, mem_cnt_n;
  logic               rd_inflight, rd_inflight_n;
  logic               out_valid_q, out_valid_n;
  logic [DATA_W-1:0]  out_data_q, out_data_n;
  logic [COUNT_W-1:0] count_q, count_n;

  logic rd_issue_c;
  logic in_ready_c;
  logic wr_en_c;

  // Issue/accept decisions and next-state; a read in flight never overlaps a
  // full holding register, so capture and pop are mutually exclusive.
  always_comb begin
    rd_issue_c    = 1'b0;
    in_ready_c    = 1'b0;
    wr_en_c       = 1'b0;
    wr_ptr_n      = wr_ptr;
    rd_ptr_n      = rd_ptr;
    mem_cnt_n     = mem_cnt;
    rd_inflight_n = 1'b0;
    out_valid_n   = out_valid_q;
    out_data_n    = out_data_q;

    rd_issue_c = !rst && (mem_cnt != '0) && !rd_inflight &&
                 (!out_valid_q || bus.out_ready);
    in_ready_c = !rst && (mem_cnt < COUNT_W'(DEPTH)) && !rd_issue_c;
    wr_en_c    = bus.in_valid && in_ready_c;

    wr_ptr_n      = wr_ptr + ADDR_W'(wr_en_c);
    rd_ptr_n      = rd_ptr + ADDR_W'(rd_issue_c);
    mem_cnt_n     = mem_cnt + COUNT_W'(wr_en_c) - COUNT_W'(rd_issue_c);
    rd_inflight_n = rd_issue_c;

    if (rd_inflight) begin
      out_valid_n = 1'b1;
      out_data_n  = bus.mem_Dout;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_n = 1'b0;
    end

    count_n = mem_cnt_n + COUNT_W'(rd_inflight_n) + COUNT_W'(out_valid_n);
  end

  // State register; reset also drops any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_cnt     <= '0;
      rd_inflight <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      count_q     <= '0;
    end else begin
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      mem_cnt     <= mem_cnt_n;
      rd_inflight <= rd_inflight_n;
      out_valid_q <= out_valid_n;
      out_data_q  <= out_data_n;
      count_q     <= count_n;
    end
  end

  // RAM port is combinational because the RAM registers address and data itself.
  always_comb begin
    bus.mem_WR      = wr_en_c;
    bus.mem_Din     = bus.in_data;
    bus.mem_address = wr_en_c ? wr_ptr : rd_ptr;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.count     = count_q;

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst; all state SHALL update on posedge clk.
REQ-002 The ports SHALL be as follows:
  clk  in  1  system clock
  rst  in  1  synchronous active-high reset
  in_data  in  2  write data from producer
  in_valid  in  1  producer offers in_data
  in_ready  out  1  block accepts in_data this cycle
  out_data  out  2  head-of-queue data to consumer
  out_valid  out  1  out_data valid
  out_ready  in  1  consumer takes out_data this cycle
  mem_address  out  2  address to external 4x2 synchronous RAM
  mem_Din  out  2  RAM write data
  mem_WR  out  1  RAM write enable
  mem_Dout  in  2  RAM registered read data; valid the cycle after the address is presented; read-before-write
  count  out  3  total entries held, 0..5
REQ-003 The signals mem_address, mem_WR and mem_Din SHALL be combinational from the current state and inputs, because the RAM registers them.

Function
REQ-004 The block SHALL implement a 5-entry FIFO: 4 entries in the RAM plus one output holding register (out_data/out_valid).
REQ-005 The internal state SHALL consist of the 2-bit pointers wr_ptr and rd_ptr, a 3-bit mem_cnt (0..4), rd_inflight, out_valid and out_data.
REQ-006 The block SHALL issue a read in cycle t (rd_issue) iff mem_cnt>0, !rd_inflight, and (!out_valid or out_ready).
REQ-007 On rd_issue: mem_address=rd_ptr, mem_WR=0; at the clock edge, rd_ptr increments mod 4, mem_cnt decrements, and rd_inflight is set.
REQ-008 in_ready SHALL be 1 iff !rst, mem_cnt<4 and !rd_issue; reads have priority over writes because the RAM port is single-ported.
REQ-009 A write SHALL occur when in_valid and in_ready are both high, with mem_address=wr_ptr, mem_WR=1 and mem_Din=in_data; at the edge, wr_ptr increments mod 4 and mem_cnt increments.
REQ-010 When idle (no read, no write), outputs SHALL be mem_WR=0, mem_address=rd_ptr and mem_Din=in_data.
REQ-011 In the cycle after rd_issue, mem_Dout SHALL be captured into out_data, out_valid set, and rd_inflight cleared.
REQ-012 On a pop (out_valid and out_ready) with no capture that cycle, out_valid SHALL clear at the edge; the capture rule in REQ-006 guarantees the slot is free.
REQ-013 Read throughput SHALL be at most one issued read per 2 cycles; write throughput SHALL be one per cycle while no read is issued.
REQ-014 Latency from an empty FIFO SHALL be: write accepted in cycle t, rd_issue in t+1, out_valid high in t+3.
REQ-015 count SHALL equal mem_cnt + rd_inflight + out_valid, registered-consistent (reflecting state after the last edge).
REQ-016 Full condition: at mem_cnt=4, in_ready SHALL be 0; a push attempted while not ready SHALL be ignored with no state change.
REQ-017 Empty condition: at count=0, out_valid SHALL be 0; an out_ready with out_valid=0 SHALL have no effect.
REQ-018 Pointers SHALL wrap 3->0 with no loss; data order SHALL be strictly FIFO.
REQ-019 The block SHALL never drive mem_WR=1 and perform a read issue in the same cycle.

Reset
REQ-020 With rst high at an edge: wr_ptr=0, rd_ptr=0, mem_cnt=0, rd_inflight=0, out_valid=0, out_data=2'b00, count=0.
REQ-021 While rst is high: in_ready=0 and mem_WR=0.
REQ-022 A read in flight at reset SHALL be discarded; the mem_Dout of the following cycle SHALL be ignored.
REQ-023 RAM contents SHALL be unaffected by reset and treated as garbage; no entry SHALL be readable until it is rewritten.

Verification
REQ-024 Scenario: after reset, push 2'b10 in cycle 0 with out_ready=1 -> mem_WR=1, address 0 in cycle 0; rd_issue in cycle 1; out_valid=1, out_data=2'b10 in cycle 3; count returns to 0 after the pop.
REQ-025 Scenario: hold out_ready=0 and push 1,2,3,0,1,2 continuously -> first entry reaches out_data; count saturates at 5; in_ready=0 with mem_cnt=4; the 6th push is held until a pop occurs.
REQ-026 Scenario: from full, set out_ready=1 and drop in_valid -> outputs 1,2,3,0,1 in order, one per 2 cycles; count steps 5->0; empty thereafter.
REQ-027 Scenario: continuous in_valid and out_ready for 40 cycles with a random pattern -> order preserved across pointer wrap; in_ready low exactly on rd_issue cycles; mem_WR and read never coincide.
REQ-028 Scenario: assert rst in the cycle after rd_issue -> the next cycle shows out_valid=0, count=0, in_ready=0; the stale mem_Dout is never presented on out_data.
REQ-029 Scenario: out_ready toggled every cycle while the FIFO is non-empty -> no duplicated or dropped entries, and count matches the reference model each cycle.
